packed_word_assembler: RTL and testbench
========================================

// Module: packed_word_assembler
// PURPOSE
//  Deserializer: collects a serial bit stream into a WIDTH-bit packed word.
//  Reverse of walking a packed vector bit by bit. Bit i of the stream lands in data[i] (LSB-first) or data[WIDTH-1-i] (MSB-first).
//  Sits between a 1-bit serial source (valid/ready) and a word consumer (valid/ready).
//  Supports early flush of a partial word with its bit count.
// PARAMETERS
//  WIDTH      16  bits per word (>=2)
//  MSB_FIRST  0   0: first accepted bit -> word_data[0]; 1: first bit -> word_data[WIDTH-1]
// PORTS
//  clk         in   1                 single clock, all logic on posedge
//  rst         in   1                 synchronous, active-high reset
//  bit_valid   in   1                 serial source has a bit
//  bit_in      in   1                 serial bit value
//  bit_ready   out  1                 assembler accepts a bit this cycle
//  flush       in   1                 emit current partial word (pulse)
//  word_valid  out  1                 word_data/word_len valid
//  word_ready  in   1                 consumer accepts word
//  word_data   out  WIDTH             assembled packed word
//  word_len    out  $clog2(WIDTH+1)   number of valid bits in word_data (1..WIDTH)
// BEHAVIOUR
//  Reset: state=COLLECT, count=0, shift reg=0; bit_ready=1 combinationally from state; word_valid=0, word_data=0, word_len=0.
//  Reset mid-operation discards the partial word and any held word. No output is produced for it.
//  States:
//   COLLECT: bit_ready=1, word_valid=0.
//    A bit is accepted on bit_valid&&bit_ready at the posedge.
//    The bit is written to its index position; all other positions are unchanged; count++.
//    The accepted bit that makes count==WIDTH: go to HOLD, word_len=WIDTH.
//    flush && count>0 (after including any bit accepted the same cycle): go to HOLD, word_len=count.
//     Unfilled positions read 0.
//    flush && count==0 && no bit accepted: ignored.
//    If the WIDTH-th bit and flush coincide: treat as a full word, word_len=WIDTH.
//   HOLD: word_valid=1, bit_ready=0.
//    word_data/word_len are stable until handshake; flush is ignored.
//    On word_valid&&word_ready: go to COLLECT, count=0, shift reg cleared.
//  Latency: word_valid rises in the cycle after the completing bit or flush edge.
//  bit_ready rises in the cycle after the word handshake. This gives one bubble per word (throughput WIDTH bits per WIDTH+1 cycles).
//  No combinational path from any input to any output other than via state registers.
//  count width is $clog2(WIDTH+1); count never exceeds WIDTH; it wraps only via the handshake clear.
//  bit_in is ignored when bit_valid=0 or bit_ready=0.
// TESTING
//  T1 LSB-first: feed bits 0,1,0,1,1,1,1,1,0,0,0,0,1,0,0,0 with word_ready=1 -> word_data=16'h10FA, word_len=16, word_valid for 1 cycle.
//  T2 MSB_FIRST=1: feed 0001_0000_1111_1010 in order -> word_data=16'h10FA, word_len=16.
//  T3 backpressure: complete 16'h10FA with word_ready=0 for 5 cycles -> word_valid and data held stable, bit_ready=0 throughout.
//     Then word_ready=1 -> handshake; bit_ready=1 the next cycle.
//  T4 flush: 4 bits 1,0,1,0 (LSB-first), then flush -> word_data=16'h0005, word_len=4.
//     flush with count=0 -> no word_valid.
//  T5 reset mid-word: 7 bits, then rst for 1 cycle -> all outputs 0, count=0.
//     Next 16 bits of 16'hFFFF -> word_data=16'hFFFF (no stale bits).
//  T6 back-to-back: continuous bit_valid, word_ready=1, words 16'h10FA then 16'hA5A5 -> both correct, exactly one bubble cycle between them.

Source files
------------

// File: rtl/packed_word_assembler.sv
// Serial-to-parallel word assembler: packs accepted serial bits into a WIDTH-bit word,
// LSB-first or MSB-first, with early flush of a partial word and its bit count.
module packed_word_assembler #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  input  logic             flush,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word_data,
  output logic [CW-1:0]    word_len,
  output logic             dbg_state,
  output logic [CW-1:0]    dbg_count
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both high.
  // bit_ready and word_valid come straight from the state register, so no input
  // reaches an output combinationally.
  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n, count_inc, idx;
  logic [CW-1:0]    len_q, len_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             accept;

  assign accept    = (state == COLLECT) && bit_valid;
  assign count_inc = count + {{(CW-1){1'b0}}, accept};
  assign idx       = MSB_FIRST ? (CW'(WIDTH - 1) - count) : count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      count <= '0;
      shreg <= '0;
      len_q <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      shreg <= shreg_n;
      len_q <= len_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    shreg_n = shreg;
    len_n   = len_q;
    case (state)
      COLLECT: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (accept && (idx == CW'(i))) shreg_n[i] = bit_in;
        end
        count_n = count_inc;
        // A completing bit wins over a coincident flush: the word is simply full.
        if (count_inc == CW'(WIDTH)) begin
          state_n = HOLD;
          len_n   = CW'(WIDTH);
        end else if (flush && (count_inc != '0)) begin
          state_n = HOLD;
          len_n   = count_inc;
        end
      end
      HOLD: begin
        if (word_ready) begin
          state_n = COLLECT;
          count_n = '0;
          shreg_n = '0;
          len_n   = '0;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  assign bit_ready  = (state == COLLECT);
  assign word_valid = (state == HOLD);
  assign word_data  = shreg;
  assign word_len   = len_q;
  assign dbg_state  = state;
  assign dbg_count  = count;

endmodule

// File: tb/tb_packed_word_assembler.sv
// Directed bench for packed_word_assembler: one LSB-first and one MSB-first instance
// driven from a single linear sequence of steps with hand-computed expectations.
module tb_packed_word_assembler;

  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          bv   [2];
  logic          bin  [2];
  logic          fl   [2];
  logic          wrdy [2];
  logic          brdy [2];
  logic          wv   [2];
  logic [W-1:0]  wd   [2];
  logic [CW-1:0] wl   [2];
  logic          dst  [2];
  logic [CW-1:0] dcnt [2];

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  packed_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bit_valid(bv[0]), .bit_in(bin[0]), .bit_ready(brdy[0]),
    .flush(fl[0]), .word_valid(wv[0]), .word_ready(wrdy[0]), .word_data(wd[0]),
    .word_len(wl[0]), .dbg_state(dst[0]), .dbg_count(dcnt[0])
  );

  packed_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bit_valid(bv[1]), .bit_in(bin[1]), .bit_ready(brdy[1]),
    .flush(fl[1]), .word_valid(wv[1]), .word_ready(wrdy[1]), .word_data(wd[1]),
    .word_len(wl[1]), .dbg_state(dst[1]), .dbg_count(dcnt[1])
  );

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle(input int s);
    bv[s] = 1'b0;
    bin[s] = 1'b0;
    fl[s] = 1'b0;
  endtask

  // Send n bits of w in stream order (bit 0 first); brdy must be high for each.
  task automatic send_bits(input int s, input logic [W-1:0] w, input int n, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      bv[s]  = 1'b1;
      bin[s] = w[i];
      if (brdy[s] !== 1'b1) bad++;
      step();
    end
    bv[s] = 1'b0;
    chk({tag, "_bit_ready_during_fill"}, 32'(bad), 32'd0);
  endtask

  task automatic expect_word(input int s, input logic [W-1:0] d, input int len, input string tag);
    chk({tag, "_valid"}, 32'(wv[s]), 32'd1);
    chk({tag, "_data"}, 32'(wd[s]), 32'(d));
    chk({tag, "_len"}, 32'(wl[s]), 32'(len));
    chk({tag, "_bit_ready_low"}, 32'(brdy[s]), 32'd0);
  endtask

  // Complete the handshake with word_ready high and confirm the assembler reopens.
  task automatic take_word(input int s, input string tag);
    wrdy[s] = 1'b1;
    step();
    chk({tag, "_valid_dropped"}, 32'(wv[s]), 32'd0);
    chk({tag, "_bit_ready_back"}, 32'(brdy[s]), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      idle(s);
      wrdy[s] = 1'b1;
    end
    step();
    step();
    rst = 1'b0;

    // Reset state on both instances
    for (int s = 0; s < 2; s++) begin
      chk("rst_valid", 32'(wv[s]), 32'd0);
      chk("rst_data", 32'(wd[s]), 32'd0);
      chk("rst_len", 32'(wl[s]), 32'd0);
      chk("rst_bit_ready", 32'(brdy[s]), 32'd1);
      chk("rst_count", 32'(dcnt[s]), 32'd0);
    end

    // T1: LSB-first 0,1,0,1,1,1,1,1,0,0,0,0,1,0,0,0 -> 16'h10FA
    send_bits(0, 16'h10FA, 16, "t1");
    expect_word(0, 16'h10FA, 16, "t1");
    take_word(0, "t1");

    // T2: MSB-first stream 0001_0000_1111_1010 -> 16'h10FA
    send_bits(1, 16'h5F08, 16, "t2");
    expect_word(1, 16'h10FA, 16, "t2");
    take_word(1, "t2");
    // MSB-first flush of 1,0,1,0 fills the top nibble
    send_bits(1, 16'h0005, 4, "t2f");
    fl[1] = 1'b1;
    step();
    fl[1] = 1'b0;
    expect_word(1, 16'hA000, 4, "t2f");
    take_word(1, "t2f");

    // T3: backpressure with incoming bits and a flush that must both be ignored
    wrdy[0] = 1'b0;
    send_bits(0, 16'h10FA, 16, "t3");
    bv[0] = 1'b1;
    bin[0] = 1'b1;
    fl[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      expect_word(0, 16'h10FA, 16, "t3_hold");
      step();
    end
    idle(0);
    expect_word(0, 16'h10FA, 16, "t3_last");
    take_word(0, "t3");
    chk("t3_count_cleared", 32'(dcnt[0]), 32'd0);

    // T4: flush of 1,0,1,0 -> 16'h0005 len 4
    send_bits(0, 16'h0005, 4, "t4");
    fl[0] = 1'b1;
    step();
    fl[0] = 1'b0;
    expect_word(0, 16'h0005, 4, "t4");
    take_word(0, "t4");
    // Flush with nothing collected is ignored
    fl[0] = 1'b1;
    step();
    fl[0] = 1'b0;
    chk("t4_empty_flush_valid", 32'(wv[0]), 32'd0);
    step();
    chk("t4_empty_flush_valid2", 32'(wv[0]), 32'd0);
    // Flush coinciding with a bit includes that bit: 1,1,0 then 1+flush -> 16'h000B len 4
    send_bits(0, 16'h0003, 3, "t4c");
    bv[0] = 1'b1;
    bin[0] = 1'b1;
    fl[0] = 1'b1;
    step();
    idle(0);
    expect_word(0, 16'h000B, 4, "t4c");
    take_word(0, "t4c");
    // WIDTH-th bit with flush is a full word
    send_bits(0, 16'h7FFF, 15, "t4w");
    bv[0] = 1'b1;
    bin[0] = 1'b0;
    fl[0] = 1'b1;
    step();
    idle(0);
    expect_word(0, 16'h7FFF, 16, "t4w");
    take_word(0, "t4w");

    // T5: reset mid-word discards the partial word
    send_bits(0, 16'h007F, 7, "t5");
    chk("t5_count_pre", 32'(dcnt[0]), 32'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_valid", 32'(wv[0]), 32'd0);
    chk("t5_rst_data", 32'(wd[0]), 32'd0);
    chk("t5_rst_len", 32'(wl[0]), 32'd0);
    chk("t5_rst_count", 32'(dcnt[0]), 32'd0);
    chk("t5_rst_bit_ready", 32'(brdy[0]), 32'd1);
    // A single 0 bit flushed must not show any of the pre-reset ones
    send_bits(0, 16'h0000, 1, "t5z");
    fl[0] = 1'b1;
    step();
    fl[0] = 1'b0;
    expect_word(0, 16'h0000, 1, "t5z");
    take_word(0, "t5z");
    send_bits(0, 16'hFFFF, 16, "t5f");
    expect_word(0, 16'hFFFF, 16, "t5f");
    take_word(0, "t5f");

    // T6: back-to-back words with bit_valid held high -> exactly one bubble
    wrdy[0] = 1'b1;
    begin
      logic [W-1:0] w2;
      w2 = 16'hA5A5;
      send_bits(0, 16'h10FA, 16, "t6a");
      bv[0] = 1'b1;
      bin[0] = w2[0];
      expect_word(0, 16'h10FA, 16, "t6a");
      step();
      chk("t6_bubble_valid", 32'(wv[0]), 32'd0);
      chk("t6_bubble_ready", 32'(brdy[0]), 32'd1);
      chk("t6_bubble_count", 32'(dcnt[0]), 32'd0);
      send_bits(0, w2, 16, "t6b");
      expect_word(0, 16'hA5A5, 16, "t6b");
      take_word(0, "t6b");
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
